// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg
//   Shared definitions for the two-requester APB arbiter: default widths,
//   the access timeout, the address bit that selects between the two
//   slaves, and the transfer FSM state encoding.
package apb_arb_pkg;

    localparam int ADDR_W_DEF  = 9;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 16;

    // Address bit that picks the slave: 0 -> PSEL1, 1 -> PSEL2.
    localparam int SEL_BIT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

endpackage

// File: rtl/apb_rr_grant.sv
// apb_rr_grant
//   Combinational two-way round-robin grant.
//   Ports:
//     valid_i [1:0]  request lines (bit N = requester N)
//     ptr_i          priority pointer; the requester it names wins a tie
//     grant_o [1:0]  one-hot grant, all zero when nothing is requested
module apb_rr_grant (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_i ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Shares one APB bus between two requesters. Picks a winner round-robin,
//   runs the SETUP/ACCESS phases itself, decodes addr[8] into PSEL1/PSEL2,
//   bounds the wait for PREADY with a timeout, and returns a one-cycle
//   response (rdata, err) to the requester that owned the transfer.
//
//   Requester handshake: a requester raises rN_valid with its command and
//   holds it until rN_ready is seen high; the command is taken on the
//   rising edge where rN_valid && rN_ready. rN_ready is only ever high in
//   IDLE. The response is a single-cycle rN_rsp_valid pulse with no
//   back-pressure.
//
//   Ports:
//     PCLK, PRESET              clock, asynchronous active-high reset
//     rN_valid/write/addr/wdata command from requester N (N = 0, 1)
//     rN_ready                  command accepted this cycle (combinational)
//     rN_rsp_valid/rdata/err    registered completion for requester N
//     PSEL1, PSEL2, PENABLE,
//     PWRITE, PADDR, PWDATA     APB master outputs
//     PRDATA1/2, PREADY1/2,
//     PSLVERR                   APB slave returns
//     dbg_state_o               current FSM state (apb_arb_pkg::state_e)
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              r0_valid,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_rdata,
    output logic              r0_rsp_err,

    input  logic              r1_valid,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_rdata,
    output logic              r1_rsp_err,

    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [7:0]        PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY1,
    input  logic              PREADY2,
    input  logic              PSLVERR,

    output logic [1:0]        dbg_state_o
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                id_q, id_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [1:0]          grant;
    logic                accept;
    logic                sel2;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;
    logic                done;
    logic                active;

    apb_rr_grant u_grant (
        .valid_i ({r1_valid, r0_valid}),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    assign accept      = (state_q == IDLE) && (grant != 2'b00);
    assign sel2        = addr_q[SEL_BIT];
    // Only the selected slave's PREADY/PRDATA are looked at.
    assign sel_ready   = sel2 ? PREADY2 : PREADY1;
    assign sel_rdata   = sel2 ? PRDATA2 : PRDATA1;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    // A PREADY on the last allowed cycle wins over the timeout.
    assign done        = (state_q == ACCESS) && (sel_ready || timeout_hit);
    assign active      = (state_q == SETUP) || (state_q == ACCESS);

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, pointer, timeout counter and response next values
    always_comb begin
        ptr_d   = ptr_q;
        id_d    = id_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            id_d    = grant[1];
            ptr_d   = ~grant[1];
            wr_d    = grant[1] ? r1_write : r0_write;
            addr_d  = grant[1] ? r1_addr  : r0_addr;
            wdata_d = grant[1] ? r1_wdata : r0_wdata;
        end

        // Zero while in SETUP, so the first ACCESS cycle sees 0.
        cnt_d = (state_q == ACCESS) ? cnt_q + CNT_W'(1) : '0;

        rsp_valid_d = 2'b00;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if (done) begin
            rsp_valid_d = id_q ? 2'b10 : 2'b01;
            rsp_err_d   = sel_ready ? PSLVERR : 1'b1;
            if (sel_ready && !wr_q && !PSLVERR) begin
                rsp_rdata_d = sel_rdata;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Output logic: APB outputs are gated by state so they read 0 in IDLE
    // and drop at once when reset forces the state back to IDLE.
    always_comb begin
        PSEL1        = active && !sel2;
        PSEL2        = active && sel2;
        PENABLE      = (state_q == ACCESS);
        PWRITE       = active && wr_q;
        PADDR        = active ? addr_q[SEL_BIT-1:0] : 8'h00;
        PWDATA       = active ? wdata_q : '0;

        r0_ready     = (state_q == IDLE) && grant[0];
        r1_ready     = (state_q == IDLE) && grant[1];

        r0_rsp_valid = rsp_valid_q[0];
        r0_rsp_err   = rsp_valid_q[0] && rsp_err_q;
        r0_rsp_rdata = rsp_valid_q[0] ? rsp_rdata_q : '0;
        r1_rsp_valid = rsp_valid_q[1];
        r1_rsp_err   = rsp_valid_q[1] && rsp_err_q;
        r1_rsp_rdata = rsp_valid_q[1] ? rsp_rdata_q : '0;

        dbg_state_o  = state_q;
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       r0_valid, r0_write, r0_ready, r0_rsp_valid, r0_rsp_err;
  logic [8:0] r0_addr;
  logic [7:0] r0_wdata, r0_rsp_rdata;
  logic       r1_valid, r1_write, r1_ready, r1_rsp_valid, r1_rsp_err;
  logic [8:0] r1_addr;
  logic [7:0] r1_wdata, r1_rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2, PSLVERR;
  logic [1:0] dbg_state;

  // scoreboard entry: {requester id, err, rdata}
  logic [9:0] exp_q[$];
  logic [9:0] mon_act, mon_other, mon_exp;

  int tests = 0;
  int fails = 0;

  apb_req_arbiter dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r0_rsp_err(r0_rsp_err),
    .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .r1_rsp_err(r1_rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .PSLVERR(PSLVERR),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic v, input logic wr,
                         input logic [8:0] a, input logic [7:0] d);
    if (id == 0) begin
      r0_valid = v; r0_write = wr; r0_addr = a; r0_wdata = d;
    end else begin
      r1_valid = v; r1_write = wr; r1_addr = a; r1_wdata = d;
    end
  endtask

  // One complete transfer from a single requester. The unselected slave
  // drives PREADY=1 during wait states; glitch drives PSLVERR during waits.
  task automatic run_xfer(input int id, input logic wr, input logic [8:0] a,
                          input logic [7:0] wd, input logic [7:0] rd, input int waits,
                          input logic glitch, input logic perr, input logic [9:0] exp);
    logic sel2;
    logic [2:0] en_exp;
    sel2 = a[8];
    en_exp = sel2 ? 3'b101 : 3'b011;
    set_req(id, 1'b1, wr, a, wd);
    PREADY1 = 1'b0; PREADY2 = 1'b0; PSLVERR = 1'b0;
    PRDATA1 = sel2 ? ~rd : rd;
    PRDATA2 = sel2 ? rd : ~rd;
    #1;
    chk("ready_own",   (id == 0) ? r0_ready : r1_ready, 1);
    chk("ready_other", (id == 0) ? r1_ready : r0_ready, 0);
    exp_q.push_back(exp);
    tick();                                   // SETUP
    set_req(id, 1'b0, 1'b0, 9'h000, 8'h00);
    chk("setup_sel", {PSEL2, PSEL1, PENABLE}, sel2 ? 3'b100 : 3'b010);
    chk("setup_cmd", {PWRITE, PADDR, PWDATA}, {wr, a[7:0], wd});
    tick();                                   // first ACCESS
    for (int w = 0; w < waits; w++) begin
      if (sel2) PREADY1 = 1'b1; else PREADY2 = 1'b1;
      PSLVERR = glitch;
      #1;
      chk("wait_sel", {PSEL2, PSEL1, PENABLE}, en_exp);
      chk("wait_rsp", {r0_rsp_valid, r1_rsp_valid}, 2'b00);
      tick();
    end
    PREADY1 = !sel2; PREADY2 = sel2; PSLVERR = perr;
    #1;
    chk("access_sel", {PSEL2, PSEL1, PENABLE}, en_exp);
    chk("access_cmd", {PWRITE, PADDR, PWDATA}, {wr, a[7:0], wd});
    tick();                                   // back in IDLE, response cycle
    PREADY1 = 1'b0; PREADY2 = 1'b0; PSLVERR = 1'b0;
    #1;
    chk("rsp_latency", (id == 0) ? r0_rsp_valid : r1_rsp_valid, 1);
    chk("idle_apb", {PSEL2, PSEL1, PENABLE, PWRITE}, 4'b0000);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge PCLK);
      if (!PRESET && (r0_rsp_valid || r1_rsp_valid)) begin
        mon_act   = r1_rsp_valid ? {1'b1, r1_rsp_err, r1_rsp_rdata}
                                 : {1'b0, r0_rsp_err, r0_rsp_rdata};
        mon_other = r1_rsp_valid ? {r0_rsp_valid, r0_rsp_err, r0_rsp_rdata}
                                 : {r1_rsp_valid, r1_rsp_err, r1_rsp_rdata};
        chk("rsp_other_quiet", mon_other, 10'h000);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got %0h expected no response", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("rsp", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic seen;
    PRESET = 1'b1;
    set_req(0, 1'b0, 1'b0, 9'h000, 8'h00);
    set_req(1, 1'b0, 1'b0, 9'h000, 8'h00);
    PRDATA1 = 8'h00; PRDATA2 = 8'h00;
    PREADY1 = 1'b0; PREADY2 = 1'b0; PSLVERR = 1'b0;
    repeat (3) tick();
    PRESET = 1'b0;
    #1;
    chk("reset_ctl", {r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err,
                      r1_rsp_err, PSEL1, PSEL2, PENABLE, PWRITE}, 10'h000);
    chk("reset_data", {PADDR, PWDATA, r0_rsp_rdata, r1_rsp_rdata}, 32'h0);
    chk("reset_state", dbg_state, IDLE);
    tick();

    // r0 write to slave 2, zero wait
    run_xfer(0, 1'b1, 9'h13C, 8'hD9, 8'h5A, 0, 1'b0, 1'b0, {1'b0, 1'b0, 8'h00});
    // r1 read from slave 1, two wait states
    run_xfer(1, 1'b0, 9'h00C, 8'h00, 8'hF9, 2, 1'b0, 1'b0, {1'b1, 1'b0, 8'hF9});
    // r0 read with PSLVERR on the PREADY cycle: err, rdata forced to 0
    run_xfer(0, 1'b0, 9'h1F0, 8'h00, 8'hA5, 1, 1'b0, 1'b1, {1'b0, 1'b1, 8'h00});
    // r1 write, PSLVERR only during wait states: no error
    run_xfer(1, 1'b1, 9'h044, 8'h3C, 8'h5A, 2, 1'b1, 1'b0, {1'b1, 1'b0, 8'h00});

    // timeout: r0 read from slave 1, PREADY1 never rises
    set_req(0, 1'b1, 1'b0, 9'h020, 8'h00);
    PRDATA1 = 8'h99; PREADY1 = 1'b0; PREADY2 = 1'b0;
    #1;
    chk("to_ready", r0_ready, 1);
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    tick();                                   // SETUP
    set_req(0, 1'b0, 1'b0, 9'h000, 8'h00);
    tick();                                   // ACCESS cycle 1 of 16
    repeat (15) tick();                       // ACCESS cycle 16
    chk("to_last_access", {PENABLE, PSEL1, r0_rsp_valid}, 3'b110);
    tick();
    chk("to_rsp", {r0_rsp_valid, PENABLE}, 2'b10);
    chk("to_idle", dbg_state, IDLE);
    // next request served normally
    run_xfer(1, 1'b0, 9'h1AB, 8'h00, 8'h7E, 0, 1'b0, 1'b0, {1'b1, 1'b0, 8'h7E});

    // reset in ACCESS: r0 starts a write (pointer then points at r1)
    set_req(0, 1'b1, 1'b1, 9'h0AA, 8'h55);
    #1;
    chk("rst_xfer_ready", r0_ready, 1);
    tick();
    set_req(0, 1'b0, 1'b0, 9'h000, 8'h00);
    tick();                                   // ACCESS, PREADY1 low
    #2;
    PRESET = 1'b1;
    #1;
    chk("rst_async_apb", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}, 20'h0);
    tick();
    tick();
    PRESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (r0_rsp_valid || r1_rsp_valid) seen = 1'b1;
      tick();
    end
    chk("rst_no_rsp", seen, 0);

    // both requesters valid continuously: r0 first, then alternate
    set_req(0, 1'b1, 1'b0, 9'h005, 8'h00);
    set_req(1, 1'b1, 1'b0, 9'h105, 8'h00);
    PRDATA1 = 8'h11; PRDATA2 = 8'h22; PREADY1 = 1'b1; PREADY2 = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(r0_ready || r1_ready) && n < 20) begin
        tick();
        n++;
      end
      chk("rr_gap", n, (g == 0) ? 0 : 2);
      chk("rr_grant", {r1_ready, r0_ready}, (g % 2 == 0) ? 2'b01 : 2'b10);
      exp_q.push_back((g % 2 == 0) ? {1'b0, 1'b0, 8'h11} : {1'b1, 1'b0, 8'h22});
      tick();
    end
    set_req(0, 1'b0, 1'b0, 9'h000, 8'h00);
    set_req(1, 1'b0, 1'b0, 9'h000, 8'h00);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
